// File: rtl/shift_arbiter.sv
// Round-robin arbiter that time-shares one barrel shifter between two requesters
// and registers each result into a single response slot with backpressure.

module barrel_shifter #(
  parameter int N = 32,
  parameter int M = 5
) (
  input  logic [N-1:0] data,
  input  logic [M-1:0] shamt,
  input  logic         left,
  output logic [N-1:0] result
);

  // Stage i shifts by 2**i when shamt[i] is set; right shifts replicate the sign bit.
  logic signed [N-1:0] stage [0:M];

  assign stage[0] = data;

  for (genvar i = 0; i < M; i++) begin : g_level
    localparam int SH = 1 << i;
    always_comb begin
      stage[i+1] = stage[i];
      if (shamt[i]) begin
        if (left) stage[i+1] = stage[i] << SH;
        else      stage[i+1] = stage[i] >>> SH;
      end
    end
  end

  assign result = stage[M];

endmodule

module shift_arbiter #(
  parameter int N = 32,
  parameter int M = 5
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [N-1:0] req0_data,
  input  logic [M-1:0] req0_shamt,
  input  logic         req0_left,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [N-1:0] req1_data,
  input  logic [M-1:0] req1_shamt,
  input  logic         req1_left,
  output logic         resp_valid,
  input  logic         resp_ready,
  output logic [N-1:0] resp_data,
  output logic         resp_id
);

  logic         resp_valid_q, resp_valid_d;
  logic [N-1:0] resp_data_q,  resp_data_d;
  logic         resp_id_q,    resp_id_d;
  logic         last_q,       last_d;

  logic         any_valid;
  logic         grant_idx;
  logic         can_accept;
  logic         accept;
  logic [N-1:0] sh_data;
  logic [M-1:0] sh_shamt;
  logic         sh_left;
  logic [N-1:0] sh_result;

  // Grant index defaults to 0 when nobody requests, so the shifter mux then sees requester 0.
  always_comb begin
    any_valid  = req0_valid | req1_valid;
    grant_idx  = (req0_valid && req1_valid) ? ~last_q : req1_valid;
    can_accept = !resp_valid_q || resp_ready;
    accept     = any_valid && can_accept && !reset;
    req0_ready = accept && !grant_idx;
    req1_ready = accept && grant_idx;
    sh_data    = grant_idx ? req1_data  : req0_data;
    sh_shamt   = grant_idx ? req1_shamt : req0_shamt;
    sh_left    = grant_idx ? req1_left  : req0_left;
  end

  barrel_shifter #(.N(N), .M(M)) u_shifter (
    .data   (sh_data),
    .shamt  (sh_shamt),
    .left   (sh_left),
    .result (sh_result)
  );

  always_comb begin
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
    resp_id_d    = resp_id_q;
    last_d       = last_q;
    if (accept) begin
      resp_valid_d = 1'b1;
      resp_data_d  = sh_result;
      resp_id_d    = grant_idx;
      last_d       = grant_idx;
    end else if (resp_ready) begin
      resp_valid_d = 1'b0;
    end
  end

  // last resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clock) begin
    if (reset) begin
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_id_q    <= 1'b0;
      last_q       <= 1'b1;
    end else begin
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_id_q    <= resp_id_d;
      last_q       <= last_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_id    = resp_id_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// Bench for shift_arbiter: directed scenarios followed by random traffic against a
// transaction-level model of the slot, round-robin grant and shift arithmetic.

module tb_shift_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        req0_valid, req0_ready, req0_left;
  logic [31:0] req0_data;
  logic [4:0]  req0_shamt;
  logic        req1_valid, req1_ready, req1_left;
  logic [31:0] req1_data;
  logic [4:0]  req1_shamt;
  logic        resp_valid, resp_ready, resp_id;
  logic [31:0] resp_data;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  shift_arbiter #(.N(32), .M(5)) dut (
    .clock      (clock),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_data  (req0_data),
    .req0_shamt (req0_shamt),
    .req0_left  (req0_left),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_data  (req1_data),
    .req1_shamt (req1_shamt),
    .req1_left  (req1_left),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_id    (resp_id)
  );

  // Reference shift: left is a plain truncating shift, right sign-extends to 64 bits first.
  function automatic logic [31:0] ref_shift(input logic [31:0] d, input int s, input logic l);
    logic [63:0] w;
    if (l) return d << s;
    w = {{32{d[31]}}, d};
    w = w >> s;
    return w[31:0];
  endfunction

  task automatic edge_step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req0_valid = 1'b1; req0_data = 32'h5; req0_shamt = 5'd1; req0_left = 1'b1;
    req1_valid = 1'b1; req1_data = 32'h7; req1_shamt = 5'd1; req1_left = 1'b1;
    resp_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_cmp++;
      if ({req0_ready, req1_ready} !== 2'b00) begin
        n_err++; $display("FAIL reset_ready got %b expected 00", {req0_ready, req1_ready});
      end
      edge_step();
      n_cmp++;
      if ({resp_valid, resp_id, resp_data} !== {1'b0, 1'b0, 32'h0}) begin
        n_err++; $display("FAIL reset_resp got v=%b id=%b d=%h expected 0/0/0", resp_valid, resp_id, resp_data);
      end
    end
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      n_err++; $display("FAIL reset_first_grant got %b expected 10", {req0_ready, req1_ready});
    end
    edge_step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    n_cmp++;
    if ({resp_valid, resp_id, resp_data} !== {1'b1, 1'b0, 32'hA}) begin
      n_err++; $display("FAIL reset_first_resp got v=%b id=%b d=%h expected 1/0/0000000a", resp_valid, resp_id, resp_data);
    end
    edge_step();
  endtask

  task automatic test_left();
    req0_valid = 1'b1; req0_data = 32'h1; req0_shamt = 5'd4; req0_left = 1'b1;
    #1;
    n_cmp++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      n_err++; $display("FAIL left_ready got %b expected 10", {req0_ready, req1_ready});
    end
    edge_step();
    req0_valid = 1'b0;
    n_cmp++;
    if ({resp_valid, resp_id, resp_data} !== {1'b1, 1'b0, 32'h10}) begin
      n_err++; $display("FAIL left_resp got v=%b id=%b d=%h expected 1/0/00000010", resp_valid, resp_id, resp_data);
    end
    edge_step();
  endtask

  task automatic test_right();
    req1_valid = 1'b1; req1_data = 32'h8000_0000; req1_shamt = 5'd4; req1_left = 1'b0;
    edge_step();
    n_cmp++;
    if ({resp_valid, resp_id, resp_data} !== {1'b1, 1'b1, 32'hF800_0000}) begin
      n_err++; $display("FAIL right_sign got v=%b id=%b d=%h expected 1/1/f8000000", resp_valid, resp_id, resp_data);
    end
    req1_data = 32'h7FFF_FFFF; req1_shamt = 5'd31;
    edge_step();
    req1_valid = 1'b0;
    n_cmp++;
    if ({resp_valid, resp_id, resp_data} !== {1'b1, 1'b1, 32'h0}) begin
      n_err++; $display("FAIL right_pos31 got v=%b id=%b d=%h expected 1/1/00000000", resp_valid, resp_id, resp_data);
    end
    edge_step();
  endtask

  task automatic test_contention();
    logic exp_id;
    exp_id = 1'b0;
    req0_valid = 1'b1; req0_data = 32'hA; req0_shamt = 5'd0; req0_left = 1'b1;
    req1_valid = 1'b1; req1_data = 32'hB; req1_shamt = 5'd0; req1_left = 1'b0;
    resp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      n_cmp++;
      if ({req0_ready, req1_ready} !== {!exp_id, exp_id}) begin
        n_err++; $display("FAIL contention_ready[%0d] got %b expected %b", k, {req0_ready, req1_ready}, {!exp_id, exp_id});
      end
      edge_step();
      n_cmp++;
      if ({resp_valid, resp_id, resp_data} !== {1'b1, exp_id, (exp_id ? 32'hB : 32'hA)}) begin
        n_err++; $display("FAIL contention_resp[%0d] got id=%b d=%h expected id=%b", k, resp_id, resp_data, exp_id);
      end
      exp_id = !exp_id;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    edge_step();
  endtask

  task automatic test_backpressure();
    req0_valid = 1'b1; req0_data = 32'h3; req0_shamt = 5'd1; req0_left = 1'b1;
    resp_ready = 1'b0;
    edge_step();
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_data = 32'h100; req1_shamt = 5'd2; req1_left = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_cmp++;
      if ({req0_ready, req1_ready} !== 2'b00) begin
        n_err++; $display("FAIL bp_ready[%0d] got %b expected 00", k, {req0_ready, req1_ready});
      end
      edge_step();
      n_cmp++;
      if ({resp_valid, resp_id, resp_data} !== {1'b1, 1'b0, 32'h6}) begin
        n_err++; $display("FAIL bp_hold[%0d] got v=%b id=%b d=%h expected 1/0/00000006", k, resp_valid, resp_id, resp_data);
      end
    end
    resp_ready = 1'b1;
    #1;
    n_cmp++;
    if ({req0_ready, req1_ready} !== 2'b01) begin
      n_err++; $display("FAIL bp_refill_ready got %b expected 01", {req0_ready, req1_ready});
    end
    edge_step();
    req1_valid = 1'b0;
    n_cmp++;
    if ({resp_valid, resp_id, resp_data} !== {1'b1, 1'b1, 32'h40}) begin
      n_err++; $display("FAIL bp_refill got v=%b id=%b d=%h expected 1/1/00000040", resp_valid, resp_id, resp_data);
    end
    edge_step();
    n_cmp++;
    if (resp_valid !== 1'b0) begin
      n_err++; $display("FAIL bp_drain got v=%b expected 0", resp_valid);
    end
  endtask

  task automatic test_reset_mid();
    req0_valid = 1'b1; req0_data = 32'h1234_5678; req0_shamt = 5'd0; req0_left = 1'b1;
    resp_ready = 1'b0;
    edge_step();
    req0_valid = 1'b0;
    n_cmp++;
    if ({resp_valid, resp_data} !== {1'b1, 32'h1234_5678}) begin
      n_err++; $display("FAIL rstmid_full got v=%b d=%h expected 1/12345678", resp_valid, resp_data);
    end
    reset = 1'b1;
    req1_valid = 1'b1; req1_data = 32'h1; req1_shamt = 5'd0; req1_left = 1'b1;
    resp_ready = 1'b1;
    #1;
    n_cmp++;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      n_err++; $display("FAIL rstmid_ready got %b expected 00", {req0_ready, req1_ready});
    end
    edge_step();
    reset = 1'b0;
    req1_valid = 1'b0;
    n_cmp++;
    if ({resp_valid, resp_id, resp_data} !== {1'b0, 1'b0, 32'h0}) begin
      n_err++; $display("FAIL rstmid_clear got v=%b id=%b d=%h expected 0/0/0", resp_valid, resp_id, resp_data);
    end
    for (int k = 0; k < 3; k++) begin
      edge_step();
      n_cmp++;
      if (resp_valid !== 1'b0) begin
        n_err++; $display("FAIL rstmid_stale[%0d] got v=%b expected 0", k, resp_valid);
      end
    end
  endtask

  task automatic test_random();
    logic        m_valid, m_id, m_last;
    logic [31:0] m_data;
    logic        hold0, hold1, g, acc, e0, e1;
    int          wait0, wait1;
    // Model state after the preceding directed tests: slot empty, last grant was requester 1.
    m_valid = 1'b0; m_id = 1'b0; m_data = 32'h0; m_last = 1'b1;
    hold0 = 1'b0; hold1 = 1'b0; wait0 = 0; wait1 = 0;
    for (int c = 0; c < 400; c++) begin
      if (!hold0) begin
        req0_valid = ($urandom_range(0, 2) != 0);
        req0_data  = $urandom; req0_shamt = 5'($urandom_range(0, 31)); req0_left = 1'($urandom_range(0, 1));
      end
      if (!hold1) begin
        req1_valid = ($urandom_range(0, 2) != 0);
        req1_data  = $urandom; req1_shamt = 5'($urandom_range(0, 31)); req1_left = 1'($urandom_range(0, 1));
      end
      resp_ready = ($urandom_range(0, 3) != 0);
      if (req0_valid && req1_valid) g = !m_last;
      else                          g = req1_valid;
      acc = (req0_valid || req1_valid) && (!m_valid || resp_ready);
      e0 = acc && !g;
      e1 = acc && g;
      #1;
      n_cmp++;
      if ({req0_ready, req1_ready} !== {e0, e1}) begin
        n_err++; $display("FAIL rand_ready[%0d] got %b expected %b", c, {req0_ready, req1_ready}, {e0, e1});
      end
      wait0 = (req0_valid && !e0 && e1) ? wait0 + 1 : (e0 ? 0 : wait0);
      wait1 = (req1_valid && !e1 && e0) ? wait1 + 1 : (e1 ? 0 : wait1);
      n_cmp++;
      if (wait0 > 1 || wait1 > 1) begin
        n_err++; $display("FAIL rand_fairness[%0d] got waits %0d/%0d expected at most 1", c, wait0, wait1);
      end
      hold0 = req0_valid && !e0;
      hold1 = req1_valid && !e1;
      if (acc) begin
        m_valid = 1'b1;
        m_id    = g;
        m_last  = g;
        m_data  = g ? ref_shift(req1_data, int'(req1_shamt), req1_left)
                    : ref_shift(req0_data, int'(req0_shamt), req0_left);
      end else if (resp_ready) begin
        m_valid = 1'b0;
      end
      edge_step();
      n_cmp++;
      if (resp_valid !== m_valid) begin
        n_err++; $display("FAIL rand_valid[%0d] got %b expected %b", c, resp_valid, m_valid);
      end
      if (m_valid) begin
        n_cmp++;
        if ({resp_id, resp_data} !== {m_id, m_data}) begin
          n_err++; $display("FAIL rand_resp[%0d] got id=%b d=%h expected id=%b d=%h", c, resp_id, resp_data, m_id, m_data);
        end
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0; resp_ready = 1'b1;
    edge_step();
  endtask

  initial begin
    reset = 1'b1;
    req0_valid = 1'b0; req0_data = '0; req0_shamt = '0; req0_left = 1'b0;
    req1_valid = 1'b0; req1_data = '0; req1_shamt = '0; req1_left = 1'b0;
    resp_ready = 1'b0;
    @(posedge clock);
    #1;
    test_reset();
    test_left();
    test_right();
    test_contention();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/shift_arbiter.md
# shift_arbiter

Two-requester arbiter and sequencer for the shared 32-bit barrel shifter in the ALU datapath. Each requester presents an operand, a shift amount and a direction through a valid/ready handshake. The block grants one requester per cycle using round-robin, drives the single internal `barrel_shifter` instance, and registers the result into a one-entry response slot with backpressure. This removes the need for a second shifter when the ALU and the address/immediate unit both need shifts.

## Interface

**Parameters**
- `N`, 32: data width.
- `M`, 5: shift-amount width; must equal log2(N).

**Ports**
- `clock`, input, 1: sole clock; all state changes on the rising edge.
- `reset`, input, 1: synchronous, active-high.
- `req0_valid`, input, 1: requester 0 has an operation pending.
- `req0_ready`, output, 1: requester 0's operation is accepted this cycle.
- `req0_data`, input, N: operand for requester 0.
- `req0_shamt`, input, M: shift amount for requester 0.
- `req0_left`, input, 1: 1 selects logical left; 0 selects arithmetic right (sign fill).
- `req1_valid`, `req1_ready`, `req1_data`, `req1_shamt`, `req1_left`: same as above, for requester 1.
- `resp_valid`, output, 1: the response slot holds a result.
- `resp_ready`, input, 1: the consumer takes the result this cycle.
- `resp_data`, output, N: shifted result.
- `resp_id`, output, 1: index of the requester that owns `resp_data`.

## Operation

**Slot state machine** (one bit, `resp_valid`). States are EMPTY and FULL.
- `can_accept` = EMPTY, or FULL with `resp_ready` = 1 (drain and refill in the same cycle).
- EMPTY → FULL on an accept.
- FULL → EMPTY when `resp_ready` = 1 and there is no accept.
- FULL → FULL when `resp_ready` = 1 and there is an accept; the slot is overwritten with the new result.
- FULL holds when `resp_ready` = 0.

**Arbitration**
- Grant register `last` holds the last requester granted.
- With only one `reqX_valid` high, that requester is granted.
- With both high, the requester not equal to `last` is granted.
- `reqX_ready` = grantX & `can_accept`. It is combinational, never asserted without the matching valid, and at most one ready is high per cycle.
- On an accept:
  - `last` ← granted index.
  - `resp_data` ← shifter output for the granted operands.
  - `resp_id` ← granted index.
- With no accept, `last` holds.

**Shifter use**
- The shifter input mux selects the granted requester's data, shamt and left. When there is no grant it selects requester 0; the result is then unused.
- `shamt` = 0 passes data through unchanged.
- Right shifts always replicate `data[N-1]`; there is no logical right shift.

**Requester rules**
- A requester must hold its `valid` and operands stable until `ready`.
- The arbiter samples operands only in the accepting cycle.

**Reset**
- Outputs and state after reset: `resp_valid` = 0, `resp_data` = 0, `resp_id` = 0, `last` = 1 (requester 0 wins the first tie).
- Both `reqX_ready` read 0 during any cycle in which `reset` = 1.
- Reset asserted while FULL discards the held result; no response is emitted for it.

## Timing

- Latency: an accept at edge T makes `resp_valid` = 1 with the result after T, visible in cycle T+1.
- Throughput: one operation per cycle while `resp_ready` stays high.
- With `resp_ready` low and the slot FULL, both readies drop in the same cycle. No operand is lost, because requesters hold.
- Round-robin bound: a continuously valid requester is granted within 2 accepts.
- `resp_data` and `resp_id` are stable while `resp_valid` = 1 and `resp_ready` = 0.
- Critical path: request mux → 5-level shifter → slot register. It must close in one cycle at the ALU clock.

## Test plan

1. **Reset:** hold `reset` 2 cycles with both valids high → readies 0, `resp_valid` = 0, `resp_data` = 0x00000000; first cycle after release grants req0.
2. **Single left shift:** req0 data 0x00000001, shamt 4, left 1 → `req0_ready` = 1 in the same cycle; next cycle `resp_valid` = 1, `resp_data` = 0x00000010, `resp_id` = 0.
3. **Arithmetic right with sign fill:** req1 data 0x80000000, shamt 4, left 0 → `resp_data` = 0xF8000000, `resp_id` = 1. Then data 0x7FFFFFFF, shamt 31 → 0x00000000.
4. **Contention:** both valid for 4 cycles with `resp_ready` = 1, req0 data 0xA, req1 data 0xB, shamt 0 → grants alternate 0,1,0,1; `resp_id` sequence 0,1,0,1; data 0xA, 0xB, 0xA, 0xB.
5. **Backpressure:** fill the slot, then hold `resp_ready` = 0 for 3 cycles with req1 valid → `req1_ready` = 0 and `resp_data` unchanged for those 3 cycles. Raise `resp_ready` → drain and accept in the same cycle; the new result appears the next cycle.
6. **Reset mid-operation:** slot FULL with 0x12345678 and `resp_ready` = 0, assert `reset` → the next cycle shows `resp_valid` = 0 and `resp_data` = 0, and no stale response ever appears.
